// File: rtl/rule_cfg_pkg.sv
// -----------------------------------------------------------------------------
// rule_cfg_pkg
// Shared definitions for the rule-table configuration path.
//   - Arbiter state encoding (also used by debug/visibility logic elsewhere).
//   - Default read data returned when a rule-side transaction times out.
//   - rw encoding of the configuration port, shared with the rule table.
// -----------------------------------------------------------------------------
package rule_cfg_pkg;

    // Arbiter state encoding
    localparam logic [1:0] ARB_IDLE_S = 2'd0;
    localparam logic [1:0] ARB_WAIT_S = 2'd1;
    localparam logic [1:0] ARB_HOLD_S = 2'd2;
    localparam logic [1:0] ARB_REL_S  = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE = ARB_IDLE_S,
        ARB_WAIT = ARB_WAIT_S,
        ARB_HOLD = ARB_HOLD_S,
        ARB_REL  = ARB_REL_S
    } arb_state_e;

    // Read data substituted for a transaction the rule side never acked
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Configuration port rw encoding
    localparam logic CFG_RD = 1'b0;
    localparam logic CFG_WR = 1'b1;

endpackage : rule_cfg_pkg

// File: rtl/rule_cfg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// one position after the last granted index, wrapping at N-1 -> 0, and
// returns the first set bit.
// Ports:
//   req   in  N      request vector
//   last  in  IDX_W  index granted most recently
//   grant out IDX_W  selected index (0 when valid is low)
//   valid out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(last) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_v = IDX_W'(idx);
            // First hit wins; later candidates are ignored once valid is set.
            if (!valid && req[idx_v]) begin
                valid = 1'b1;
                grant = idx_v;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rule_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// rule_cfg_arbiter
// Shares the single rule-table configuration port between NUM_REQ masters.
// Round-robin, one transaction at a time, four-phase cs/ack sequencing on
// both sides, with a watchdog so a stuck rule port cannot hang a master.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_cs/rw         per-master chip select / 0:read 1:write
//   req_addr/wdata    per-master address (16b) and write data (32b), packed
//   req_ack           per-master ack, one-hot or zero (registered)
//   req_err           high with req_ack when the transaction timed out
//   req_rdata         read data, valid while req_ack is high
//   cfg2rule_*        registered request to the rule table
//   rule2cfg_ack/rdata  response from the rule table
//
// Optional build macro RULE_ARB_STAT_EN adds:
//   stat_txn_cnt (32, wrapping), stat_tmo_cnt (16, saturating),
//   stat_sticky_err (set by any WAIT or RELEASE timeout, cleared by reset).
// -----------------------------------------------------------------------------
module rule_cfg_arbiter
    import rule_cfg_pkg::*;
#(
    parameter int          NUM_REQ   = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_cs,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    req_err,
    output logic [31:0]             req_rdata,
    output logic                    cfg2rule_cs,
    output logic                    cfg2rule_rw,
    output logic [15:0]             cfg2rule_addr,
    output logic [31:0]             cfg2rule_wdata,
    input  logic                    rule2cfg_ack,
    input  logic [31:0]             rule2cfg_rdata
`ifdef RULE_ARB_STAT_EN
    ,
    output logic [31:0]             stat_txn_cnt,
    output logic [15:0]             stat_tmo_cnt,
    output logic                    stat_sticky_err
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One spare bit so the counter can step past TIMEOUT on the abort cycle.
    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               rw_q, rw_d;
    logic [15:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               sel_rw;
    logic [15:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               cnt_hit;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_cs),
        .last  (last_q),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    // Request fields of the candidate master, muxed with constant selects.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[i*16 +: 16];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    assign cnt_hit = (cnt_q == TMO_CNT);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (rule2cfg_ack) begin
                    // Captured for writes too; the master ignores it then.
                    rdata_d        = rule2cfg_rdata;
                    ack_d          = '0;
                    ack_d[gnt_q]   = 1'b1;
                    err_d          = 1'b0;
                    state_d        = ARB_HOLD;
                end else if (cnt_hit) begin
                    // Abort: drop cs now so the rule side can recover while
                    // the master is still completing its handshake.
                    rdata_d        = ERR_RDATA;
                    ack_d          = '0;
                    ack_d[gnt_q]   = 1'b1;
                    err_d          = 1'b1;
                    cs_d           = 1'b0;
                    state_d        = ARB_HOLD;
                end
            end

            ARB_HOLD: begin
                if (!req_cs[gnt_q]) begin
                    ack_d   = '0;
                    err_d   = 1'b0;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ARB_REL;
                end
            end

            ARB_REL: begin
                // The rule side resynchronises cs, so its ack lags cs by a
                // few cycles; granting before it falls would alias the old
                // ack onto the next transaction.
                cnt_d = cnt_q + 1'b1;
                if (!rule2cfg_ack || cnt_hit) begin
                    state_d = ARB_IDLE;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);  // master 0 wins first
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ack        = ack_q;
    assign req_err        = err_q;
    assign req_rdata      = rdata_q;
    assign cfg2rule_cs    = cs_q;
    assign cfg2rule_rw    = rw_q;
    assign cfg2rule_addr  = addr_q;
    assign cfg2rule_wdata = wdata_q;

`ifdef RULE_ARB_STAT_EN
    logic        grant_evt, wait_tmo_evt, rel_tmo_evt;
    logic [31:0] stat_txn_q, stat_txn_d;
    logic [15:0] stat_tmo_q, stat_tmo_d;
    logic        stat_sticky_q, stat_sticky_d;

    assign grant_evt    = (state_q == ARB_IDLE) && pick_valid;
    assign wait_tmo_evt = (state_q == ARB_WAIT) && !rule2cfg_ack && cnt_hit;
    assign rel_tmo_evt  = (state_q == ARB_REL) && rule2cfg_ack && cnt_hit;

    always_comb begin
        stat_txn_d    = stat_txn_q;
        stat_tmo_d    = stat_tmo_q;
        stat_sticky_d = stat_sticky_q;
        if (grant_evt) begin
            stat_txn_d = stat_txn_q + 32'd1;
        end
        if (wait_tmo_evt && (stat_tmo_q != 16'hFFFF)) begin
            stat_tmo_d = stat_tmo_q + 16'd1;
        end
        if (wait_tmo_evt || rel_tmo_evt) begin
            stat_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_txn_q    <= '0;
            stat_tmo_q    <= '0;
            stat_sticky_q <= 1'b0;
        end else begin
            stat_txn_q    <= stat_txn_d;
            stat_tmo_q    <= stat_tmo_d;
            stat_sticky_q <= stat_sticky_d;
        end
    end

    assign stat_txn_cnt    = stat_txn_q;
    assign stat_tmo_cnt    = stat_tmo_q;
    assign stat_sticky_err = stat_sticky_q;
`endif

endmodule : rule_cfg_arbiter

// File: tb/tb_rule_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rule_cfg_arbiter
// Directed bench for rule_cfg_arbiter with a behavioural rule-table model
// (programmable ack delay, release delay, or no ack at all).
// -----------------------------------------------------------------------------
module tb_rule_cfg_arbiter;
    import rule_cfg_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int TB_TIMEOUT = 16;
    localparam int BUDGET     = 2000;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_cs;
    logic [NUM_REQ-1:0]    req_rw;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  req_err;
    logic [31:0]           req_rdata;
    logic                  cfg2rule_cs;
    logic                  cfg2rule_rw;
    logic [15:0]           cfg2rule_addr;
    logic [31:0]           cfg2rule_wdata;
    logic                  rule2cfg_ack;
    logic [31:0]           rule2cfg_rdata;
`ifdef RULE_ARB_STAT_EN
    logic [31:0]           stat_txn_cnt;
    logic [15:0]           stat_tmo_cnt;
    logic                  stat_sticky_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Rule-table model controls and storage
    int          ack_dly = 2;
    int          rel_dly = 0;
    bit          no_ack  = 1'b0;
    int          dly_cnt = 0;
    logic [31:0] mem [16];

    logic [15:0] grant_log [$];

    rule_cfg_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TIMEOUT   (TB_TIMEOUT),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_cs         (req_cs),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ack        (req_ack),
        .req_err        (req_err),
        .req_rdata      (req_rdata),
        .cfg2rule_cs    (cfg2rule_cs),
        .cfg2rule_rw    (cfg2rule_rw),
        .cfg2rule_addr  (cfg2rule_addr),
        .cfg2rule_wdata (cfg2rule_wdata),
        .rule2cfg_ack   (rule2cfg_ack),
        .rule2cfg_rdata (rule2cfg_rdata)
`ifdef RULE_ARB_STAT_EN
        ,
        .stat_txn_cnt    (stat_txn_cnt),
        .stat_tmo_cnt    (stat_tmo_cnt),
        .stat_sticky_err (stat_sticky_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rule-table model: acks ack_dly cycles after seeing cs, drops ack
    // rel_dly cycles after cs falls. Updates land #1 after the clock edge.
    initial begin
        rule2cfg_ack   = 1'b0;
        rule2cfg_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rule2cfg_ack) begin
                if (cfg2rule_cs && !no_ack) begin
                    if (dly_cnt >= ack_dly) begin
                        if (cfg2rule_rw == CFG_WR) begin
                            mem[cfg2rule_addr[3:0]] = cfg2rule_wdata;
                        end
                        rule2cfg_rdata = mem[cfg2rule_addr[3:0]];
                        rule2cfg_ack   = 1'b1;
                        dly_cnt        = 0;
                    end else begin
                        dly_cnt++;
                    end
                end else begin
                    dly_cnt = 0;
                end
            end else begin
                if (!cfg2rule_cs) begin
                    if (dly_cnt >= rel_dly) begin
                        rule2cfg_ack = 1'b0;
                        dly_cnt      = 0;
                    end else begin
                        dly_cnt++;
                    end
                end else begin
                    dly_cnt = 0;
                end
            end
        end
    end

    // Every new rule-side transaction must start with the previous ack gone.
    initial begin
        logic prev_cs;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            if (cfg2rule_cs && !prev_cs) begin
                check("cs_rise_ack_low", 32'(rule2cfg_ack), 32'd0);
                grant_log.push_back(cfg2rule_addr);
            end
            prev_cs = cfg2rule_cs;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    task automatic start_m(input int m, input logic rw, input logic [15:0] addr,
                           input logic [31:0] wdata);
        req_rw[m]              = rw;
        req_addr[m*16 +: 16]   = addr;
        req_wdata[m*32 +: 32]  = wdata;
        req_cs[m]              = 1'b1;
    endtask

    task automatic wait_ack(input int m, input string tag);
        int n;
        n = 0;
        while (req_ack[m] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack"}, 32'(req_ack[m]), 32'd1);
        check({tag, "_onehot"}, 32'(req_ack), 32'd1 << m);
    endtask

    task automatic end_m(input int m, input string tag);
        int n;
        n = 0;
        req_cs[m] = 1'b0;
        while (req_ack[m] !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_drop"}, 32'(req_ack[m]), 32'd0);
    endtask

    task automatic txn(input int m, input logic rw, input logic [15:0] addr,
                       input logic [31:0] wdata, input string tag,
                       output logic [31:0] rdata, output logic err);
        @(negedge clk);
        start_m(m, rw, addr, wdata);
        @(negedge clk);
        wait_ack(m, tag);
        rdata = req_rdata;
        err   = req_err;
        end_m(m, tag);
    endtask

    initial begin
        logic [31:0] rd0, rd1;
        logic        er0, er1;
        logic [15:0] exp_log [4];
        int          n;

        foreach (mem[i]) mem[i] = 32'h0;
        rst_n     = 1'b0;
        req_cs    = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_cs", 32'(cfg2rule_cs), 32'd0);
        check("rst_rw", 32'(cfg2rule_rw), 32'd0);
        check("rst_addr", 32'(cfg2rule_addr), 32'd0);
        check("rst_wdata", cfg2rule_wdata, 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_err", 32'(req_err), 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- single write, master 0 ----
        ack_dly = 2;
        start_m(0, CFG_WR, 16'h0005, 32'h3000_0002);
        @(negedge clk);
        check("wr_cs_latency", 32'(cfg2rule_cs), 32'd1);
        check("wr_rw", 32'(cfg2rule_rw), 32'(CFG_WR));
        check("wr_addr", 32'(cfg2rule_addr), 32'h0005);
        check("wr_wdata", cfg2rule_wdata, 32'h3000_0002);
        check("wr_ack_early", 32'(req_ack), 32'd0);
        wait_ack(0, "wr");
        check("wr_err", 32'(req_err), 32'd0);
        end_m(0, "wr");
        check("wr_mem", mem[5], 32'h3000_0002);

        // ---- read back through the arbiter ----
        txn(0, CFG_RD, 16'h0005, 32'h0, "rdback", rd0, er0);
        check("rdback_data", rd0, 32'h3000_0002);
        check("rdback_err", 32'(er0), 32'd0);

        // ---- single read, master 1, slow ack ----
        mem[5]  = 32'h1234_5678;
        ack_dly = 6;
        txn(1, CFG_RD, 16'h0005, 32'h0, "rd1", rd1, er1);
        check("rd1_data", rd1, 32'h1234_5678);
        check("rd1_err", 32'(er1), 32'd0);

        // ---- contention: both masters, two transactions each ----
        ack_dly = 2;
        grant_log.delete();
        fork
            begin
                txn(0, CFG_WR, 16'h00A0, 32'hA0A0_0001, "ct0a", rd0, er0);
                txn(0, CFG_WR, 16'h00A0, 32'hA0A0_0002, "ct0b", rd0, er0);
            end
            begin
                txn(1, CFG_WR, 16'h00B1, 32'hB1B1_0001, "ct1a", rd1, er1);
                txn(1, CFG_WR, 16'h00B1, 32'hB1B1_0002, "ct1b", rd1, er1);
            end
        join
        exp_log = '{16'h00A0, 16'h00B1, 16'h00A0, 16'h00B1};
        check("ct_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) begin
                check($sformatf("ct_order_%0d", i), 32'(grant_log[i]), 32'(exp_log[i]));
            end
        end

        // ---- timeout, master 0 ----
        no_ack = 1'b1;
        @(negedge clk);
        start_m(0, CFG_RD, 16'h0003, 32'h0);
        n = 0;
        while (cfg2rule_cs !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cs_seen", 32'(cfg2rule_cs), 32'd1);
        n = 0;
        while (req_ack[0] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TB_TIMEOUT + 1));
        check("tmo_ack", 32'(req_ack), 32'd1);
        check("tmo_err", 32'(req_err), 32'd1);
        check("tmo_rdata", req_rdata, 32'hDEAD_BEEF);
        check("tmo_cs_dropped", 32'(cfg2rule_cs), 32'd0);
`ifdef RULE_ARB_STAT_EN
        check("tmo_stat_cnt", 32'(stat_tmo_cnt), 32'd1);
        check("tmo_stat_sticky", 32'(stat_sticky_err), 32'd1);
`endif
        end_m(0, "tmo");
        check("tmo_err_drop", 32'(req_err), 32'd0);
        no_ack = 1'b0;

        // ---- slow release with master 1 pending ----
        ack_dly = 1;
        rel_dly = 5;
        grant_log.delete();
        fork
            txn(0, CFG_WR, 16'h0007, 32'h0000_0777, "sr0", rd0, er0);
            begin
                repeat (3) @(negedge clk);
                txn(1, CFG_RD, 16'h0005, 32'h0, "sr1", rd1, er1);
            end
            begin
                int k;
                k = 0;
                while (!(rule2cfg_ack === 1'b1 && cfg2rule_cs === 1'b0) && k < BUDGET) begin
                    @(negedge clk);
                    k++;
                end
                k = 0;
                while (rule2cfg_ack === 1'b1 && k < 100) begin
                    check("sr_cs_low_while_ack", 32'(cfg2rule_cs), 32'd0);
                    @(negedge clk);
                    k++;
                end
                check("sr_ack_held", 32'(k >= 5), 32'd1);
                check("sr_cs_low_after_ack_fall", 32'(cfg2rule_cs), 32'd0);
            end
        join
        check("sr_rd1_data", rd1, 32'h1234_5678);
        check("sr_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("sr_second_grant", 32'(grant_log[1]), 32'h0005);
        end
        rel_dly = 0;

        // ---- reset while master 0 is in WAIT_ACK ----
        no_ack = 1'b1;
        @(negedge clk);
        start_m(0, CFG_WR, 16'h0009, 32'h0909_0909);
        repeat (4) @(negedge clk);
        check("mrst_pre_cs", 32'(cfg2rule_cs), 32'd1);
        rst_n  = 1'b0;
        no_ack = 1'b0;
        start_m(1, CFG_WR, 16'h000A, 32'h0A0A_0A0A);
        @(negedge clk);
        check("mrst_cs", 32'(cfg2rule_cs), 32'd0);
        check("mrst_rw", 32'(cfg2rule_rw), 32'd0);
        check("mrst_addr", 32'(cfg2rule_addr), 32'd0);
        check("mrst_wdata", cfg2rule_wdata, 32'd0);
        check("mrst_ack", 32'(req_ack), 32'd0);
        check("mrst_err", 32'(req_err), 32'd0);
        check("mrst_rdata", req_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_regrant_cs", 32'(cfg2rule_cs), 32'd1);
        check("mrst_regrant_addr", 32'(cfg2rule_addr), 32'h0009);
        wait_ack(0, "mrst0");
        end_m(0, "mrst0");
        wait_ack(1, "mrst1");
        end_m(1, "mrst1");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rule_cfg_arbiter

// File: doc/rule_cfg_arbiter.md
Name: rule_cfg_arbiter

Overview:
- Shares the single rule-table configuration port (cs/ack four-phase handshake, rw, addr, wdata, rdata) between NUM_REQ configuration masters, e.g. the local-bus CPU bridge and the in-band management engine.
- Round-robin arbitration, one transaction at a time.
- Full four-phase sequencing on both the master side and the rule side.
- Watchdog timeout so a stuck rule port cannot hang a master.

Parameters:
- NUM_REQ, 2, number of configuration masters (2..8).
- TIMEOUT, 255, max cycles waiting for a rule-side ack edge before abort.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- req_cs  in  NUM_REQ  per-master chip select, high active.
- req_rw  in  NUM_REQ  per-master 0:read 1:write.
- req_addr  in  NUM_REQ*16  per-master address, master i at [16i+15:16i].
- req_wdata  in  NUM_REQ*32  per-master write data.
- req_ack  out  NUM_REQ  per-master ack, one-hot or zero.
- req_err  out  1  high with req_ack when the transaction timed out.
- req_rdata  out  32  read data, valid while req_ack is high.
- cfg2rule_cs  out  1  to rule table.
- cfg2rule_rw  out  1  to rule table.
- cfg2rule_addr  out  16  to rule table.
- cfg2rule_wdata  out  32  to rule table.
- rule2cfg_ack  in  1  from rule table.
- rule2cfg_rdata  in  32  from rule table.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Grant pointer last = NUM_REQ-1, so master 0 wins first.
  - Timeout counter 0.
- Outputs: cfg2rule_* and req_ack/req_err/req_rdata are all registered.
- States:
  - IDLE:
    - If any req_cs is high, pick the first set bit searching from last+1 with wrap.
    - Latch grant index g; latch rw/addr/wdata of g into cfg2rule_rw/addr/wdata.
    - Set cfg2rule_cs=1; update last=g; clear the counter; go WAIT_ACK.
  - WAIT_ACK:
    - Hold cfg2rule_cs=1; increment the counter.
    - If rule2cfg_ack=1: capture rule2cfg_rdata into req_rdata (write: capture anyway, value don't-care); set req_ack[g]=1, req_err=0; go HOLD.
    - Else if counter==TIMEOUT: req_rdata=ERR_RDATA, req_ack[g]=1, req_err=1, cfg2rule_cs=0; go HOLD.
  - HOLD:
    - Keep req_ack[g] high while req_cs[g] stays high.
    - When req_cs[g]=0: req_ack=0, req_err=0, cfg2rule_cs=0; clear the counter; go RELEASE.
  - RELEASE:
    - Wait for rule2cfg_ack=0, then go IDLE.
    - If the counter reaches TIMEOUT first, go IDLE anyway (sticky error only if STAT is enabled).
    - Required because the rule side synchronises cs, so its ack falls several cycles after cs drops.
- Latency: cfg2rule_cs rises 1 cycle after a req_cs sample in IDLE. req_ack rises 1 cycle after the rule2cfg_ack sample.
- Simultaneous requests: strict round-robin. A master that holds req_cs continuously is served again only after every other pending master.
- A master dropping req_cs before its ack (protocol violation): the transaction still completes. HOLD sees req_cs low immediately, so the ack pulses for 1 cycle.
- A request arriving during RELEASE waits; there is no bypass.
- Non-granted masters never see ack.
- Reset mid-transaction: cfg2rule_cs drops on the reset cycle; the pointer and state reinitialise.

Optional Feature:
- Macro RULE_ARB_STAT_EN.
- When defined, add outputs:
  - stat_txn_cnt (32): granted transactions, wrapping.
  - stat_tmo_cnt (16): timeouts, saturating at 16'hFFFF.
  - stat_sticky_err (1): set by any WAIT_ACK or RELEASE timeout; cleared only by reset.
- All three reset to 0.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rule_cfg_pkg holds:
  - state encoding localparams ARB_IDLE_S=0, ARB_WAIT_S=1, ARB_HOLD_S=2, ARB_REL_S=3;
  - the ERR_RDATA default;
  - the rw encoding (CFG_RD=0, CFG_WR=1), shared with the rule table.
- One sub-module, rr_pick: combinational round-robin selector (req vector, last index -> grant index, valid). It is reused by other arbiters.

Test Plan:
- Single write: master 0 writes addr 16'h0005, data 32'h3000_0002. Required: cfg2rule_* carry those values; req_ack[0] rises after rule2cfg_ack; after release the rule-side read of 5 returns 32'h3000_0002.
- Single read: master 1 reads addr 16'h0005, the model returns 32'h1234_5678 after 6 cycles. Required: req_rdata=32'h1234_5678 and req_err=0 while req_ack[1] is high.
- Contention: masters 0 and 1 both request continuously, 4 transactions. Required: grant order 0,1,0,1; no overlap of cfg2rule_cs; each cs-high window is separated by rule2cfg_ack low.
- Timeout: the rule model never acks. Required: req_ack[0] and req_err rise at cycle TIMEOUT+1 after cs; req_rdata=32'hDEAD_BEEF; stat_tmo_cnt=1 with RULE_ARB_STAT_EN.
- Slow release: the model holds ack 5 cycles after cs falls while master 1 is pending. Required: master 1's cfg2rule_cs rises only after ack goes low.
- Reset in WAIT_ACK: assert rst_n=0 for 1 cycle. Required: all outputs 0 on the next edge; master 0 is granted first afterward.
